mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM-stage load/store unit; the consumer end of the EX-to-MEM interface.
- Accepts a latched EX result (memory address, store data, size, sign flag, write enable, rd/wreg/ALU data) and performs the access over a byte-wide RAM port, one byte per cycle, little-endian.
- Produces a single-cycle writeback beat for the register file.
- Holds the upstream pipeline with stall_req while an access is in flight.

Parameters:
ADDR_W, 32, RAM/effective address width
DATA_W, 32, register data width
RAM_LAT, 1, cycles from ram_a to ram_din valid (only 1 supported)

Ports:
clk  in  1  clock
rst  in  1  reset
valid_i  in  1  instruction present from EX latch
mem_en_i  in  1  instruction is load/store
mem_we_i  in  1  1=store, 0=load
mem_sel_i  in  2  access size: 0=byte, 1=half, 2=word, 3=reserved(treat as word)
load_sign_i  in  1  sign-extend load result
mem_addr_i  in  32  effective address
store_data_i  in  32  rs2 value for stores
alu_data_i  in  32  EX result for non-memory instructions
rd_i  in  5  destination register
wreg_i  in  1  destination write enable
stall_req  out  1  upstream must hold inputs
wb_valid_o  out  1  writeback beat
rd_o  out  5  writeback register
wreg_o  out  1  writeback enable (0 for stores)
wdata_o  out  32  writeback data
ram_a  out  32  RAM byte address (registered)
ram_dout  out  8  RAM write byte (registered)
ram_wr  out  1  RAM write strobe (registered)
ram_din  in  8  RAM read byte, valid 1 cycle after ram_a

Behaviour:
- Reset: rst is synchronous, active-high. On reset:
  - all outputs 0; state IDLE; byte counter 0.
  - Reset mid-access aborts: no wb_valid_o, ram_wr=0 next cycle.
- N (bytes) = 1/2/4 for mem_sel 0/1/2; 3 is treated as 4.
- Byte k addresses mem_addr+k, modulo 2^32 (0xFFFFFFFF+1 wraps to 0).
- No alignment check; misaligned accesses are legal.
- States:
  - IDLE
  - LOAD: issue address k, capture byte k-1.
  - STORE: drive byte k.
  - DONE: one-cycle writeback.
- Acceptance: in IDLE with valid_i=1.
  - mem_en_i=0: registered passthrough. Next cycle wb_valid_o=1 with rd_i/wreg_i/alu_data_i. stall_req stays 0.
  - mem_en_i=1: request latched (address, data, size, sign, rd, wreg). stall_req=1 combinationally in the accept cycle and in every cycle until the DONE cycle. stall_req=0 in DONE, so a new request can be accepted in DONE.
- Load timing:
  - ram_a=addr+k is driven in cycle k+1 after accept, k=0..N-1.
  - Byte k is captured from ram_din in cycle k+2.
  - wb_valid_o is asserted in cycle N+2 after the accept cycle.
  - Result: bytes assembled little-endian into bits [8N-1:0]. Upper bits are sign-extended from bit 8N-1 if load_sign, else zero. Word loads ignore the sign flag.
  - wreg_o=wreg_i, rd_o=rd_i.
- Store timing:
  - ram_wr=1 with ram_a=addr+k and ram_dout=store_data[8k+7:8k] in cycle k+1, k=0..N-1.
  - ram_wr=0 otherwise.
  - wb_valid_o is asserted in cycle N+1 with wreg_o=0 and wdata_o=0.
- wb_valid_o is a one-cycle pulse. rd_o/wreg_o/wdata_o hold their values until the next beat.
- ram_wr is never 1 during a load, in IDLE, or in DONE.
- In DONE with valid_i=1: the new request is accepted as if in IDLE (back-to-back, no bubble).
- Inputs changing while stall_req=1 is a protocol violation: the latched copy is used and the violation is ignored.

Decomposition:
- Shared defines package:
  - mem_sel encodings (MEM_BYTE/MEM_HALF/MEM_WORD)
  - state encodings
  - MemSelBus, RegAddrBus, RegBus widths
- Natural sub-module: mem_load_extend, a combinational size/sign extension of the assembled bytes. The rest stays in one module (FSM + byte counter + shift-assembly register).

Test Plan:
- LW at 0x100; RAM 0x100..0x103 = 78 56 34 12 -> ram_a 0x100..0x103 in cycles 1-4; wb_valid_o in cycle 6; wdata_o=0x12345678; stall_req=1 in cycles 0-5.
- LB at 0x10 holding 0x80, load_sign=1 -> wdata_o=0xFFFFFF80 in cycle 3. Repeat with load_sign=0 -> 0x00000080.
- LH at 0xFFFFFFFF; bytes FE (at 0xFFFFFFFF), FF (at 0x0); signed -> ram_a wraps to 0x0; wdata_o=0xFFFFFFFE.
- SW 0xDEADBEEF to 0x200 -> ram_wr=1 in cycles 1-4 with (0x200,EF),(0x201,BE),(0x202,AD),(0x203,DE); wb_valid_o in cycle 5 with wreg_o=0.
- rst asserted in cycle 2 of an SW -> ram_wr=0 from the next cycle; no wb_valid_o; state IDLE; a following ADD passthrough writes back normally.
- Back-to-back: SB accepted in DONE of a previous LW -> no idle cycle between them. Non-mem ops with valid_i every cycle -> wb_valid_o every cycle, stall_req=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings and widths for the MEM-stage load/store unit.
// Access-size codes, FSM states and the byte-count helper live here.
package mem_access_pkg;

  localparam int unsigned MemSelBus  = 2;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegBus     = 32;

  localparam logic [MemSelBus-1:0] MEM_BYTE = 2'd0;
  localparam logic [MemSelBus-1:0] MEM_HALF = 2'd1;
  localparam logic [MemSelBus-1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStore,
    StDone
  } state_e;

  // Reserved size code 3 behaves as a word access.
  function automatic logic [2:0] sel_bytes(input logic [MemSelBus-1:0] sel);
    case (sel)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Size/sign extension of a little-endian assembled load value whose
// valid bytes already sit in the low bits.
module mem_load_extend
  import mem_access_pkg::*;
(
  input  logic [RegBus-1:0]    i_data,
  input  logic [MemSelBus-1:0] i_sel,
  input  logic                 i_sign,
  output logic [RegBus-1:0]    o_data
);

  always_comb begin
    o_data = i_data;
    case (i_sel)
      MEM_BYTE: o_data = {{(RegBus-8){i_sign & i_data[7]}}, i_data[7:0]};
      MEM_HALF: o_data = {{(RegBus-16){i_sign & i_data[15]}}, i_data[15:0]};
      default:  o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: byte-serial access over a byte-wide RAM port,
// single-cycle writeback beat, upstream stall while an access is in flight.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = RegBus,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  mem_en_i,
  input  logic                  mem_we_i,
  input  logic [MemSelBus-1:0]  mem_sel_i,
  input  logic                  load_sign_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic [DATA_W-1:0]     alu_data_i,
  input  logic [RegAddrBus-1:0] rd_i,
  input  logic                  wreg_i,
  output logic                  stall_req,
  output logic                  wb_valid_o,
  output logic [RegAddrBus-1:0] rd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [ADDR_W-1:0]     ram_a,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr,
  input  logic [7:0]            ram_din
);

  state_e                r_state;
  logic [2:0]            r_cnt;
  logic [2:0]            r_nb;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_sdata;
  logic [DATA_W-9:0]     r_ldata;
  logic [MemSelBus-1:0]  r_sel;
  logic                  r_sign;
  logic                  r_wreg;
  logic [RegAddrBus-1:0] r_rd;

  logic              w_idle_like;
  logic              w_accept_mem;
  logic              w_load_last;
  logic              w_capture;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_aligned;
  logic [DATA_W-1:0] w_ext;

  // DONE behaves like IDLE for acceptance so back-to-back requests need no bubble.
  assign w_idle_like  = (r_state == StIdle) || (r_state == StDone);
  assign w_accept_mem = w_idle_like && valid_i && mem_en_i;
  assign stall_req    = !rst && (w_accept_mem || (r_state == StLoad) || (r_state == StStore));

  // r_cnt counts cycles since accept; byte k returns RAM_LAT cycles after its address.
  assign w_next_addr = r_addr + ADDR_W'(r_cnt);
  assign w_load_last = (r_cnt == r_nb + 3'(RAM_LAT));
  assign w_capture   = (r_cnt > 3'(RAM_LAT));

  // Bytes shift in from the top; the final value is aligned down by access size.
  assign w_shift = {ram_din, r_ldata};

  always_comb begin
    w_aligned = w_shift;
    case (r_sel)
      MEM_BYTE: w_aligned = {{(DATA_W-8){1'b0}}, w_shift[DATA_W-1 -: 8]};
      MEM_HALF: w_aligned = {{(DATA_W-16){1'b0}}, w_shift[DATA_W-1 -: 16]};
      default:  w_aligned = w_shift;
    endcase
  end

  mem_load_extend u_extend (
    .i_data (w_aligned),
    .i_sel  (r_sel),
    .i_sign (r_sign),
    .o_data (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_nb       <= '0;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_ldata    <= '0;
      r_sel      <= '0;
      r_sign     <= 1'b0;
      r_wreg     <= 1'b0;
      r_rd       <= '0;
      wb_valid_o <= 1'b0;
      rd_o       <= '0;
      wreg_o     <= 1'b0;
      wdata_o    <= '0;
      ram_a      <= '0;
      ram_dout   <= '0;
      ram_wr     <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      ram_wr     <= 1'b0;
      case (r_state)
        StLoad: begin
          if (r_cnt < r_nb) begin
            ram_a <= w_next_addr;
          end
          if (w_load_last) begin
            wb_valid_o <= 1'b1;
            rd_o       <= r_rd;
            wreg_o     <= r_wreg;
            wdata_o    <= w_ext;
            r_state    <= StDone;
          end else begin
            if (w_capture) begin
              r_ldata <= w_shift[DATA_W-1:8];
            end
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StStore: begin
          if (r_cnt < r_nb) begin
            ram_wr   <= 1'b1;
            ram_a    <= w_next_addr;
            ram_dout <= r_sdata[7:0];
            r_sdata  <= r_sdata >> 8;
            r_cnt    <= r_cnt + 3'd1;
          end else begin
            wb_valid_o <= 1'b1;
            rd_o       <= r_rd;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            r_state    <= StDone;
          end
        end
        StIdle, StDone: begin
          r_state <= StIdle;
          if (valid_i && mem_en_i) begin
            r_addr <= mem_addr_i;
            r_sel  <= mem_sel_i;
            r_nb   <= sel_bytes(mem_sel_i);
            r_sign <= load_sign_i;
            r_rd   <= rd_i;
            r_wreg <= wreg_i;
            r_cnt  <= 3'd1;
            ram_a  <= mem_addr_i;
            if (mem_we_i) begin
              ram_wr   <= 1'b1;
              ram_dout <= store_data_i[7:0];
              r_sdata  <= store_data_i >> 8;
              r_state  <= StStore;
            end else begin
              r_state <= StLoad;
            end
          end else if (valid_i) begin
            wb_valid_o <= 1'b1;
            rd_o       <= rd_i;
            wreg_o     <= wreg_i;
            wdata_o    <= alu_data_i;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table vectors, corner sequences and
// random traffic against an access-level reference model with its own RAM image.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, mem_en_i, mem_we_i, load_sign_i, wreg_i;
  logic [1:0]  mem_sel_i;
  logic [31:0] mem_addr_i, store_data_i, alu_data_i;
  logic [4:0]  rd_i;
  logic        stall_req, wb_valid_o, wreg_o, ram_wr;
  logic [4:0]  rd_o;
  logic [31:0] wdata_o, ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;

  always #5 clk = ~clk;

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .mem_en_i     (mem_en_i),
    .mem_we_i     (mem_we_i),
    .mem_sel_i    (mem_sel_i),
    .load_sign_i  (load_sign_i),
    .mem_addr_i   (mem_addr_i),
    .store_data_i (store_data_i),
    .alu_data_i   (alu_data_i),
    .rd_i         (rd_i),
    .wreg_i       (wreg_i),
    .stall_req    (stall_req),
    .wb_valid_o   (wb_valid_o),
    .rd_o         (rd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .ram_a        (ram_a),
    .ram_dout     (ram_dout),
    .ram_wr       (ram_wr),
    .ram_din      (ram_din)
  );

  // RAM image aliased on the low 12 address bits; gold uses the same mapping.
  logic [7:0] ram  [4096];
  logic [7:0] gold [4096];

  always @(posedge clk) begin
    ram_din <= ram[ram_a[11:0]];
    if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
  end

  typedef struct {
    logic        mem_en;
    logic        we;
    logic [1:0]  sel;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        wreg;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] exp_wdata;
    logic        exp_wreg;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic op_t mk_op(input logic en, input logic we, input logic [1:0] sel,
                                input logic sign, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] alu,
                                input logic [4:0] rd, input logic wreg);
    op_t o;
    o.mem_en = en; o.we = we; o.sel = sel; o.sign = sign; o.addr = addr;
    o.sdata = sdata; o.alu = alu; o.rd = rd; o.wreg = wreg;
    return o;
  endfunction

  function automatic int nbytes(input logic [1:0] sel);
    return (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input op_t o);
    logic [31:0] v;
    logic [31:0] a;
    int n;
    v = '0;
    n = nbytes(o.sel);
    for (int k = 0; k < n; k++) begin
      a = o.addr + 32'(k);
      v[8*k +: 8] = gold[a[11:0]];
    end
    if (n < 4 && o.sign && v[8*n-1]) begin
      for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  task automatic gold_store(input op_t o);
    logic [31:0] a;
    for (int k = 0; k < nbytes(o.sel); k++) begin
      a = o.addr + 32'(k);
      gold[a[11:0]] = o.sdata[8*k +: 8];
    end
  endtask

  task automatic expect_of(input op_t o, output logic [31:0] wd, output logic wr);
    if (!o.mem_en) begin
      wd = o.alu; wr = o.wreg;
    end else if (o.we) begin
      gold_store(o); wd = '0; wr = 1'b0;
    end else begin
      wd = model_load(o); wr = o.wreg;
    end
  endtask

  task automatic drive(input op_t o, input logic v);
    valid_i = v; mem_en_i = o.mem_en; mem_we_i = o.we; mem_sel_i = o.sel;
    load_sign_i = o.sign; mem_addr_i = o.addr; store_data_i = o.sdata;
    alu_data_i = o.alu; rd_i = o.rd; wreg_i = o.wreg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op from an idle unit at cycle 0 and checks every cycle through writeback.
  task automatic run_op(input op_t o, input logic [31:0] exp_wd, input logic exp_wr,
                        input string tag);
    int n, lat;
    logic [31:0] ea, sb;
    n   = nbytes(o.sel);
    lat = !o.mem_en ? 1 : (o.we ? n + 1 : n + 2);
    drive(o, 1'b1);
    for (int c = 0; c <= lat + 1; c++) begin
      if (c == 1) valid_i = 1'b0;
      #1;
      chk({tag, ".stall"}, stall_req, 32'(o.mem_en && c < lat));
      chk({tag, ".ram_wr"}, ram_wr, 32'(o.mem_en && o.we && c >= 1 && c <= n));
      if (o.mem_en && c >= 1 && c <= n) begin
        ea = o.addr + 32'(c - 1);
        chk({tag, ".ram_a"}, ram_a, ea);
        if (o.we) begin
          sb = o.sdata >> (8 * (c - 1));
          chk({tag, ".ram_dout"}, ram_dout, {24'h0, sb[7:0]});
        end
      end
      chk({tag, ".wb_valid"}, wb_valid_o, 32'(c == lat));
      if (c == lat) begin
        chk({tag, ".wdata"}, wdata_o, exp_wd);
        chk({tag, ".wreg"}, wreg_o, 32'(exp_wr));
        if (!(o.mem_en && o.we)) chk({tag, ".rd"}, rd_o, 32'(o.rd));
      end
      tick();
    end
  endtask

  vec_t        vecs[$];
  op_t         o, lw, sb;
  logic [31:0] wd;
  logic        wr;
  int          bad_wb, bad_wr, nmis;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'h00;
      gold[i] = 8'h00;
    end
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    ram[12'h010] = 8'h80; ram[12'hFFF] = 8'hFE; ram[12'h000] = 8'hFF;
    gold[12'h100] = 8'h78; gold[12'h101] = 8'h56; gold[12'h102] = 8'h34; gold[12'h103] = 8'h12;
    gold[12'h010] = 8'h80; gold[12'hFFF] = 8'hFE; gold[12'h000] = 8'hFF;

    rst = 1'b1;
    drive(mk_op(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    repeat (3) tick();
    #1;
    chk("rst.wb_valid", wb_valid_o, 0);
    chk("rst.rd", rd_o, 0);
    chk("rst.wreg", wreg_o, 0);
    chk("rst.wdata", wdata_o, 0);
    chk("rst.ram_a", ram_a, 0);
    chk("rst.ram_dout", ram_dout, 0);
    chk("rst.ram_wr", ram_wr, 0);
    chk("rst.stall", stall_req, 0);
    rst = 1'b0;
    tick();

    vecs.push_back('{mk_op(1, 0, 2, 0, 32'h100, 0, 0, 5, 1), 32'h12345678, 1'b1});
    vecs.push_back('{mk_op(1, 0, 0, 1, 32'h10, 0, 0, 6, 1), 32'hFFFFFF80, 1'b1});
    vecs.push_back('{mk_op(1, 0, 0, 0, 32'h10, 0, 0, 7, 1), 32'h00000080, 1'b1});
    vecs.push_back('{mk_op(1, 0, 1, 1, 32'hFFFFFFFF, 0, 0, 8, 1), 32'hFFFFFFFE, 1'b1});
    vecs.push_back('{mk_op(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 9, 1), 32'h0000FFFE, 1'b1});
    vecs.push_back('{mk_op(1, 1, 2, 0, 32'h200, 32'hDEADBEEF, 0, 10, 1), 32'h0, 1'b0});
    vecs.push_back('{mk_op(1, 0, 2, 1, 32'h200, 0, 0, 12, 1), 32'hDEADBEEF, 1'b1});
    vecs.push_back('{mk_op(0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 11, 1), 32'hCAFEF00D, 1'b1});
    vecs.push_back('{mk_op(1, 0, 3, 1, 32'h100, 0, 0, 13, 1), 32'h12345678, 1'b1});
    vecs.push_back('{mk_op(1, 0, 2, 1, 32'h101, 0, 0, 14, 1), 32'h00123456, 1'b1});
    vecs.push_back('{mk_op(1, 0, 1, 1, 32'h102, 0, 0, 15, 0), 32'h00001234, 1'b0});
    vecs.push_back('{mk_op(0, 0, 0, 0, 0, 0, 32'h55, 3, 0), 32'h55, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].op.mem_en && vecs[i].op.we) gold_store(vecs[i].op);
      run_op(vecs[i].op, vecs[i].exp_wdata, vecs[i].exp_wreg, $sformatf("vec%0d", i));
    end

    // Reset during cycle 2 of a word store: bytes 0 and 1 land, nothing else follows.
    o = mk_op(1, 1, 2, 0, 32'h400, 32'h11223344, 0, 4, 1);
    gold[12'h400] = 8'h44;
    gold[12'h401] = 8'h33;
    drive(o, 1'b1);
    #1 chk("rstsw.stall0", stall_req, 1);
    tick();
    valid_i = 1'b0;
    #1 chk("rstsw.wr1", ram_wr, 1);
    tick();
    rst = 1'b1;
    #1 chk("rstsw.wr2", ram_wr, 1);
    chk("rstsw.a2", ram_a, 32'h401);
    tick();
    rst = 1'b0;
    #1 chk("rstsw.wr3", ram_wr, 0);
    chk("rstsw.stall3", stall_req, 0);
    bad_wb = 0;
    bad_wr = 0;
    for (int c = 0; c < 6; c++) begin
      if (wb_valid_o !== 1'b0) bad_wb++;
      if (ram_wr !== 1'b0) bad_wr++;
      tick();
    end
    chk("rstsw.no_wb_cycles", bad_wb, 0);
    chk("rstsw.no_wr_cycles", bad_wr, 0);
    run_op(mk_op(0, 0, 0, 0, 0, 0, 32'h0BADF00D, 17, 1), 32'h0BADF00D, 1'b1, "rstsw.add");

    // LW then SB accepted in the LW's DONE cycle; inputs scribbled while stalled.
    lw = mk_op(1, 0, 2, 0, 32'h100, 0, 0, 20, 1);
    sb = mk_op(1, 1, 0, 0, 32'h500, 32'h777777A5, 0, 21, 1);
    expect_of(lw, wd, wr);
    drive(lw, 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1 chk("b2b.stall", stall_req, 1);
      chk("b2b.wb_early", wb_valid_o, 0);
      if (c >= 1 && c <= 4) chk("b2b.ram_a", ram_a, 32'h100 + 32'(c - 1));
      tick();
      if (c < 5) begin
        mem_addr_i = $urandom;
        store_data_i = $urandom;
        mem_sel_i = 2'($urandom_range(0, 3));
        load_sign_i = 1'($urandom_range(0, 1));
      end
    end
    gold_store(sb);
    drive(sb, 1'b1);
    #1 chk("b2b.lw_wb", wb_valid_o, 1);
    chk("b2b.lw_wdata", wdata_o, wd);
    chk("b2b.sb_stall", stall_req, 1);
    tick();
    valid_i = 1'b0;
    #1 chk("b2b.sb_wr", ram_wr, 1);
    chk("b2b.sb_a", ram_a, 32'h500);
    chk("b2b.sb_dout", ram_dout, 32'hA5);
    chk("b2b.sb_nowb", wb_valid_o, 0);
    tick();
    #1 chk("b2b.sb_wb", wb_valid_o, 1);
    chk("b2b.sb_wreg", wreg_o, 0);
    chk("b2b.sb_wdata", wdata_o, 0);
    tick();

    // Back-to-back passthrough ops every cycle.
    for (int i = 0; i < 6; i++) begin
      drive(mk_op(0, 0, 0, 0, 0, 0, 32'h1000 + 32'(i), 5'(i + 1), 1), 1'b1);
      #1 chk("pass.stall", stall_req, 0);
      if (i > 0) begin
        chk("pass.wb", wb_valid_o, 1);
        chk("pass.wdata", wdata_o, 32'h1000 + 32'(i - 1));
        chk("pass.rd", rd_o, 32'(i));
      end
      tick();
    end
    valid_i = 1'b0;
    #1 chk("pass.wb_last", wb_valid_o, 1);
    chk("pass.wdata_last", wdata_o, 32'h1005);
    tick();
    #1 chk("pass.wb_drop", wb_valid_o, 0);
    tick();

    for (int i = 0; i < 40; i++) begin
      o = mk_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                            : 32'h300 + 32'($urandom_range(0, 63)),
                $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
      expect_of(o, wd, wr);
      run_op(o, wd, wr, $sformatf("rnd%0d", i));
    end

    nmis = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== gold[i]) nmis++;
    chk("ram_image_mismatches", nmis, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
